vend_ctrl: RTL and testbench

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_ctrl.sv | 158 +++++++++++++++
 tb/tb_vend_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl.sv
// Vending machine controller: accepts coins into a bounded credit, vends a
// selected product through a request/acknowledge dispenser handshake with a
// timeout, and pays change back one unit per acknowledge.
module vend_ctrl #(
  parameter logic [4:0] PRICE0     = 5'd4,
  parameter logic [4:0] PRICE1     = 5'd5,
  parameter logic [4:0] PRICE2     = 5'd7,
  parameter logic [4:0] PRICE3     = 5'd9,
  parameter int         MAX_CREDIT = 15,
  parameter int         TIMEOUT    = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [1:0] Coin,
  input  logic       Sel_valid,
  input  logic [1:0] Sel,
  input  logic       Cancel,
  output logic       Disp_req,
  output logic [1:0] Disp_id,
  input  logic       Disp_ack,
  output logic       Chg_req,
  input  logic       Chg_ack,
  output logic [4:0] Credit,
  output logic       Coin_rej,
  output logic       Sel_nak,
  output logic       Fault,
  output logic       Busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CREDIT = 2'd1;
  localparam logic [1:0] S_VEND   = 2'd2;
  localparam logic [1:0] S_CHANGE = 2'd3;

  localparam logic [5:0] MAX_C   = 6'(MAX_CREDIT);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  function automatic logic [4:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = PRICE0;
      2'd1:    price_of = PRICE1;
      2'd2:    price_of = PRICE2;
      default: price_of = PRICE3;
    endcase
  endfunction

  logic [1:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [4:0] credit_d;
  logic [1:0] disp_id_d;
  logic       reject_d, nak_d, fault_d;

  // Coin arithmetic is done one bit wider so the ceiling test cannot wrap.
  logic [5:0] coin_sum;
  logic       coin_ok;
  logic [4:0] coin_add;
  logic [4:0] sel_price;
  logic [5:0] refund_sum;

  assign coin_sum   = {1'b0, Credit} + {4'b0, Coin};
  assign coin_ok    = (Coin != 2'd0) && (coin_sum <= MAX_C);
  assign coin_add   = coin_ok ? coin_sum[4:0] : Credit;
  assign sel_price  = price_of(Sel);
  assign refund_sum = {1'b0, Credit} + {1'b0, price_of(Disp_id)};

  // Next-state and next-credit decision for the four-state controller.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    credit_d  = Credit;
    timer_d   = 8'd0;
    disp_id_d = Disp_id;
    reject_d  = 1'b0;
    nak_d     = 1'b0;
    fault_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (coin_ok) begin
          credit_d = coin_sum[4:0];
          state_d  = S_CREDIT;
        end else begin
          reject_d = (Coin != 2'd0);
        end
      end

      S_CREDIT: begin
        credit_d = coin_add;
        reject_d = (Coin != 2'd0) && !coin_ok;
        if (Cancel) begin
          state_d = S_CHANGE;
        end else if (Sel_valid) begin
          // Affordability uses the registered credit; a same-cycle coin only adds afterwards.
          if (Credit >= sel_price) begin
            credit_d  = coin_add - sel_price;
            disp_id_d = Sel;
            state_d   = S_VEND;
          end else begin
            nak_d = 1'b1;
          end
        end
      end

      S_VEND: begin
        reject_d = (Coin != 2'd0);
        if (Disp_ack) begin
          state_d = (Credit != 5'd0) ? S_CHANGE : S_IDLE;
        end else if (timer_q == TO_LAST) begin
          credit_d = refund_sum[5] ? 5'd31 : refund_sum[4:0];
          fault_d  = 1'b1;
          state_d  = S_CHANGE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      default: begin
        reject_d = (Coin != 2'd0);
        if (Credit == 5'd0) begin
          state_d = S_IDLE;
        end else if (Chg_ack) begin
          credit_d = Credit - 5'd1;
          if (Credit == 5'd1) state_d = S_IDLE;
        end
      end
    endcase
  end

  // State, credit and all outputs are registered from the next-state decision.
  always_ff @(posedge Clk or negedge Reset_n) begin
    // NOTE: reset clears every register, so an interrupted vend or change is simply dropped.
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      timer_q  <= 8'd0;
      Credit   <= 5'd0;
      Disp_id  <= 2'd0;
      Disp_req <= 1'b0;
      Chg_req  <= 1'b0;
      Busy     <= 1'b0;
      Coin_rej <= 1'b0;
      Sel_nak  <= 1'b0;
      Fault    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      timer_q  <= timer_d;
      Credit   <= credit_d;
      Disp_id  <= disp_id_d;
      Disp_req <= (state_d == S_VEND);
      Chg_req  <= (state_d == S_CHANGE) && (credit_d != 5'd0);
      Busy     <= (state_d == S_VEND) || (state_d == S_CHANGE);
      Coin_rej <= reject_d;
      Sel_nak  <= nak_d;
      Fault    <= fault_d;
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed testbench for vend_ctrl with default parameters
// (prices 4/5/7/9, credit ceiling 15, dispense timeout 8 cycles).
module tb_vend_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [1:0] Coin;
  logic       Sel_valid;
  logic [1:0] Sel;
  logic       Cancel;
  logic       Disp_req;
  logic [1:0] Disp_id;
  logic       Disp_ack;
  logic       Chg_req;
  logic       Chg_ack;
  logic [4:0] Credit;
  logic       Coin_rej;
  logic       Sel_nak;
  logic       Fault;
  logic       Busy;

  int errors = 0;
  int checks = 0;

  vend_ctrl dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Coin      (Coin),
    .Sel_valid (Sel_valid),
    .Sel       (Sel),
    .Cancel    (Cancel),
    .Disp_req  (Disp_req),
    .Disp_id   (Disp_id),
    .Disp_ack  (Disp_ack),
    .Chg_req   (Chg_req),
    .Chg_ack   (Chg_ack),
    .Credit    (Credit),
    .Coin_rej  (Coin_rej),
    .Sel_nak   (Sel_nak),
    .Fault     (Fault),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  // Present one cycle of inputs, let the DUT clock them, then idle the inputs.
  // Outputs are stable for inspection when this returns (1 time unit after the edge).
  task automatic cyc(input logic [1:0] c, input logic sv, input logic [1:0] s,
                     input logic cn, input logic da, input logic ca);
    Coin = c; Sel_valid = sv; Sel = s; Cancel = cn; Disp_ack = da; Chg_ack = ca;
    @(posedge Clk);
    #1;
    Coin = 2'd0; Sel_valid = 1'b0; Sel = 2'd0; Cancel = 1'b0; Disp_ack = 1'b0; Chg_ack = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    Coin = 2'd0; Sel_valid = 1'b0; Sel = 2'd0; Cancel = 1'b0; Disp_ack = 1'b0; Chg_ack = 1'b0;
    repeat (2) @(posedge Clk);
    #3 Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    checks++; if (Credit !== 5'd0) begin errors++; $display("FAIL reset_credit: got %0d want 0", Credit); end
    checks++; if ({Disp_req, Chg_req, Busy, Coin_rej, Sel_nak, Fault} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000", {Disp_req, Chg_req, Busy, Coin_rej, Sel_nak, Fault}); end
    checks++; if (Disp_id !== 2'd0) begin errors++; $display("FAIL reset_disp_id: got %0d want 0", Disp_id); end
  endtask

  task automatic test_idle_ignore;
    cyc(2'd0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1);
    checks++; if ({Busy, Sel_nak, Chg_req, Disp_req} !== 4'b0 || Credit !== 5'd0) begin
      errors++; $display("FAIL idle_ignore: got flags %b credit %0d want 0000 credit 0", {Busy, Sel_nak, Chg_req, Disp_req}, Credit); end
  endtask

  task automatic test_basic_vend;
    cyc(2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Credit !== 5'd3) begin errors++; $display("FAIL basic_coin3: got %0d want 3", Credit); end
    cyc(2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Credit !== 5'd5) begin errors++; $display("FAIL basic_coin5: got %0d want 5", Credit); end
    cyc(2'd0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    checks++; if (Disp_req !== 1'b1 || Disp_id !== 2'd1 || Busy !== 1'b1 || Credit !== 5'd0) begin
      errors++; $display("FAIL basic_vend_entry: got req %b id %0d busy %b credit %0d want 1 1 1 0", Disp_req, Disp_id, Busy, Credit); end
    cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Disp_req !== 1'b1 || Disp_id !== 2'd1) begin
      errors++; $display("FAIL basic_vend_hold: got req %b id %0d want 1 1", Disp_req, Disp_id); end
    cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (Disp_req !== 1'b0 || Busy !== 1'b0 || Chg_req !== 1'b0) begin
      errors++; $display("FAIL basic_vend_done: got req %b busy %b chg %b want 0 0 0", Disp_req, Busy, Chg_req); end
    cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Chg_req !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL basic_no_change: got chg %b busy %b want 0 0", Chg_req, Busy); end
  endtask

  task automatic test_change_drain;
    logic [4:0] exp_credit;
    cyc(2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Credit !== 5'd9) begin errors++; $display("FAIL change_credit9: got %0d want 9", Credit); end
    cyc(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Credit !== 5'd5 || Disp_req !== 1'b1 || Disp_id !== 2'd0) begin
      errors++; $display("FAIL change_vend: got credit %0d req %b id %0d want 5 1 0", Credit, Disp_req, Disp_id); end
    cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (Chg_req !== 1'b1 || Disp_req !== 1'b0 || Busy !== 1'b1 || Credit !== 5'd5) begin
      errors++; $display("FAIL change_entry: got chg %b req %b busy %b credit %0d want 1 0 1 5", Chg_req, Disp_req, Busy, Credit); end
    cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Chg_req !== 1'b1 || Credit !== 5'd5) begin
      errors++; $display("FAIL change_wait: got chg %b credit %0d want 1 5", Chg_req, Credit); end
    exp_credit = 5'd5;
    for (int i = 0; i < 5; i++) begin
      cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
      exp_credit = exp_credit - 5'd1;
      checks++; if (Credit !== exp_credit || Chg_req !== (exp_credit != 5'd0)) begin
        errors++; $display("FAIL change_ack%0d: got credit %0d chg %b want %0d %b", i, Credit, Chg_req, exp_credit, exp_credit != 5'd0); end
    end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL change_idle: got busy %b want 0", Busy); end
    cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (Credit !== 5'd0 || Chg_req !== 1'b0) begin
      errors++; $display("FAIL change_stray_ack: got credit %0d chg %b want 0 0", Credit, Chg_req); end
  endtask

  task automatic test_coin_reject;
    for (int i = 0; i < 4; i++) cyc(2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Credit !== 5'd14) begin errors++; $display("FAIL rej_credit14: got %0d want 14", Credit); end
    cyc(2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Coin_rej !== 1'b1 || Credit !== 5'd14) begin
      errors++; $display("FAIL rej_over_max: got rej %b credit %0d want 1 14", Coin_rej, Credit); end
    cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Coin_rej !== 1'b0) begin errors++; $display("FAIL rej_pulse: got %b want 0", Coin_rej); end
    cyc(2'd1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    checks++; if (Credit !== 5'd6 || Disp_req !== 1'b1 || Disp_id !== 2'd3 || Coin_rej !== 1'b0) begin
      errors++; $display("FAIL rej_sel_coin: got credit %0d req %b id %0d rej %b want 6 1 3 0", Credit, Disp_req, Disp_id, Coin_rej); end
    cyc(2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Coin_rej !== 1'b1 || Credit !== 5'd6) begin
      errors++; $display("FAIL rej_in_vend: got rej %b credit %0d want 1 6", Coin_rej, Credit); end
    cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    drain(6);
    checks++; if (Credit !== 5'd0 || Busy !== 1'b0 || Chg_req !== 1'b0) begin
      errors++; $display("FAIL rej_drain: got credit %0d busy %b chg %b want 0 0 0", Credit, Busy, Chg_req); end
  endtask

  task automatic test_sel_nak_cancel;
    cyc(2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(2'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    checks++; if (Sel_nak !== 1'b1 || Credit !== 5'd3 || Disp_req !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL nak_low_credit: got nak %b credit %0d req %b busy %b want 1 3 0 0", Sel_nak, Credit, Disp_req, Busy); end
    cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (Sel_nak !== 1'b0 || Credit !== 5'd3 || Busy !== 1'b0) begin
      errors++; $display("FAIL nak_pulse_stray_ack: got nak %b credit %0d busy %b want 0 3 0", Sel_nak, Credit, Busy); end
    cyc(2'd3, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    checks++; if (Sel_nak !== 1'b1 || Credit !== 5'd6 || Disp_req !== 1'b0) begin
      errors++; $display("FAIL nak_same_cycle_coin: got nak %b credit %0d req %b want 1 6 0", Sel_nak, Credit, Disp_req); end
    cyc(2'd0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (Busy !== 1'b1 || Chg_req !== 1'b1 || Disp_req !== 1'b0 || Credit !== 5'd6) begin
      errors++; $display("FAIL cancel_over_sel: got busy %b chg %b req %b credit %0d want 1 1 0 6", Busy, Chg_req, Disp_req, Credit); end
    drain(6);
    checks++; if (Credit !== 5'd0 || Chg_req !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL cancel_drain: got credit %0d chg %b busy %b want 0 0 0", Credit, Chg_req, Busy); end
  endtask

  task automatic test_max_credit;
    for (int i = 0; i < 5; i++) cyc(2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Credit !== 5'd15 || Coin_rej !== 1'b0) begin
      errors++; $display("FAIL max_exact: got credit %0d rej %b want 15 0", Credit, Coin_rej); end
    cyc(2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Credit !== 5'd15 || Coin_rej !== 1'b1) begin
      errors++; $display("FAIL max_plus_one: got credit %0d rej %b want 15 1", Credit, Coin_rej); end
    cyc(2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    drain(15);
    checks++; if (Credit !== 5'd0 || Busy !== 1'b0) begin
      errors++; $display("FAIL max_drain: got credit %0d busy %b want 0 0", Credit, Busy); end
  endtask

  task automatic test_timeout;
    cyc(2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(2'd0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    checks++; if (Credit !== 5'd0 || Disp_req !== 1'b1) begin
      errors++; $display("FAIL to_vend: got credit %0d req %b want 0 1", Credit, Disp_req); end
    cyc(2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Coin_rej !== 1'b1 || Credit !== 5'd0) begin
      errors++; $display("FAIL to_coin_in_vend: got rej %b credit %0d want 1 0", Coin_rej, Credit); end
    for (int i = 0; i < 6; i++) cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Fault !== 1'b0 || Disp_req !== 1'b1) begin
      errors++; $display("FAIL to_early: got fault %b req %b want 0 1", Fault, Disp_req); end
    cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Fault !== 1'b1 || Disp_req !== 1'b0 || Credit !== 5'd7 || Chg_req !== 1'b1 || Busy !== 1'b1) begin
      errors++; $display("FAIL to_fault: got fault %b req %b credit %0d chg %b busy %b want 1 0 7 1 1", Fault, Disp_req, Credit, Chg_req, Busy); end
    cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Fault !== 1'b0 || Chg_req !== 1'b1) begin
      errors++; $display("FAIL to_fault_pulse: got fault %b chg %b want 0 1", Fault, Chg_req); end
    drain(7);
    checks++; if (Credit !== 5'd0 || Chg_req !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL to_drain: got credit %0d chg %b busy %b want 0 0 0", Credit, Chg_req, Busy); end
  endtask

  task automatic test_ack_on_timeout;
    cyc(2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (Fault !== 1'b0 || Disp_req !== 1'b0 || Busy !== 1'b0 || Credit !== 5'd0) begin
      errors++; $display("FAIL ack_on_timeout: got fault %b req %b busy %b credit %0d want 0 0 0 0", Fault, Disp_req, Busy, Credit); end
  endtask

  task automatic test_reset_mid_change;
    cyc(2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (Chg_req !== 1'b1 || Credit !== 5'd4) begin
      errors++; $display("FAIL rst_pre: got chg %b credit %0d want 1 4", Chg_req, Credit); end
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (Credit !== 5'd0 || Chg_req !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL rst_async: got credit %0d chg %b busy %b want 0 0 0", Credit, Chg_req, Busy); end
    cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    #3 Reset_n = 1'b1;
    cyc(2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (Credit !== 5'd0 || Chg_req !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL rst_stray_ack: got credit %0d chg %b busy %b want 0 0 0", Credit, Chg_req, Busy); end
    cyc(2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (Credit !== 5'd2 || Busy !== 1'b0) begin
      errors++; $display("FAIL rst_resume: got credit %0d busy %b want 2 0", Credit, Busy); end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic_vend();
    test_change_drain();
    test_coin_reject();
    test_sel_nak_cancel();
    test_max_credit();
    test_timeout();
    test_ack_on_timeout();
    test_reset_mid_change();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
